// File: rtl/icache_refill_ctrl.sv
`default_nettype none
//============================================================================
// Module   : icache_refill_ctrl
// Desc     : ICache miss/refill sequencer. Accepts one line miss, picks a
//            victim way (first invalid way, else round-robin), reads the
//            line from memory in bus-width beats, and writes data, tag and
//            valid into the cache arrays in one cycle. It also walks every
//            set to invalidate the cache on a flush (fence.i).
// Options  : `define ICACHE_REFILL_PERF_EN adds the perf_miss_cnt_o and
//            perf_busy_cnt_o counter outputs.
// Revision : 1.0 - initial release
//============================================================================
module icache_refill_ctrl #(
    parameter int PLEN                = 32,
    parameter int ICACHE_LINE_WIDTH   = 512,
    parameter int ICACHE_SET_ASSOC    = 4,
    parameter int ICACHE_NUM_SETS     = 64,
    parameter int ICACHE_INDEX_WIDTH  = $clog2(ICACHE_NUM_SETS),
    parameter int ICACHE_OFFSET_WIDTH = $clog2(ICACHE_LINE_WIDTH / 8),
    parameter int ICACHE_TAG_WIDTH    = PLEN - ICACHE_INDEX_WIDTH - ICACHE_OFFSET_WIDTH,
    parameter int BUS_WIDTH           = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    // miss request from fetch
    input  logic                          miss_valid_i,
    output logic                          miss_ready_o,
    input  logic [PLEN-1:0]               miss_paddr_i,
    input  logic [ICACHE_SET_ASSOC-1:0]   miss_way_valid_i,
    // memory read request
    output logic                          mem_req_valid_o,
    input  logic                          mem_req_ready_i,
    output logic [PLEN-1:0]               mem_req_addr_o,
    // memory read response beats
    input  logic                          mem_rsp_valid_i,
    output logic                          mem_rsp_ready_o,
    input  logic [BUS_WIDTH-1:0]          mem_rsp_data_i,
    input  logic                          mem_rsp_err_i,
    // flush
    input  logic                          flush_i,
    output logic                          flush_busy_o,
    // array write port
    output logic                          refill_we_o,
    output logic [ICACHE_INDEX_WIDTH-1:0] refill_index_o,
    output logic [ICACHE_SET_ASSOC-1:0]   refill_way_o,
    output logic [ICACHE_TAG_WIDTH-1:0]   refill_tag_o,
    output logic                          refill_valid_o,
    output logic [ICACHE_LINE_WIDTH-1:0]  refill_line_o,
    output logic                          refill_done_o,
    output logic                          refill_err_o
`ifdef ICACHE_REFILL_PERF_EN
    ,
    output logic [31:0]                   perf_miss_cnt_o,
    output logic [31:0]                   perf_busy_cnt_o
`endif
);

    localparam int c_BEATS  = ICACHE_LINE_WIDTH / BUS_WIDTH;
    localparam int c_BEAT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_WAY_W  = (ICACHE_SET_ASSOC > 1) ? $clog2(ICACHE_SET_ASSOC) : 1;

    localparam logic [c_BEAT_W-1:0]           c_LAST_BEAT = c_BEAT_W'(c_BEATS - 1);
    localparam logic [ICACHE_INDEX_WIDTH-1:0] c_LAST_SET  = ICACHE_INDEX_WIDTH'(ICACHE_NUM_SETS - 1);
    localparam logic [c_WAY_W-1:0]            c_LAST_WAY  = c_WAY_W'(ICACHE_SET_ASSOC - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_BEAT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    // Reject geometries the beat assembler cannot handle.
    generate
        if (((ICACHE_LINE_WIDTH % BUS_WIDTH) != 0) || (c_BEATS < 2)) begin : g_bad_bus_width
            $error("icache_refill_ctrl: line width must be a multiple of BUS_WIDTH with at least 2 beats");
        end
        if (PLEN != (ICACHE_TAG_WIDTH + ICACHE_INDEX_WIDTH + ICACHE_OFFSET_WIDTH)) begin : g_bad_addr_split
            $error("icache_refill_ctrl: tag + index + offset widths must equal PLEN");
        end
    endgenerate

    logic [2:0]                          r_state;
    logic [2:0]                          w_state_next;

    logic [ICACHE_INDEX_WIDTH-1:0]       r_index;
    logic [ICACHE_TAG_WIDTH-1:0]         r_tag;
    logic [ICACHE_SET_ASSOC-1:0]         r_way;
    logic [c_WAY_W-1:0]                  r_rr_ptr;
    logic [c_BEAT_W-1:0]                 r_beat_cnt;
    logic                                r_err;
    logic                                r_flush_pend;
    logic [ICACHE_INDEX_WIDTH-1:0]       r_flush_idx;
    logic [c_BEATS-1:0][BUS_WIDTH-1:0]   r_line;

    // last values driven on the array port, shown while no write is active
    logic [ICACHE_INDEX_WIDTH-1:0]       r_hold_index;
    logic [ICACHE_SET_ASSOC-1:0]         r_hold_way;
    logic [ICACHE_TAG_WIDTH-1:0]         r_hold_tag;
    logic                                r_hold_valid;
    logic [ICACHE_LINE_WIDTH-1:0]        r_hold_line;

    logic                                w_miss_acc;
    logic                                w_beat_fire;
    logic                                w_last_beat;
    logic                                w_last_set;
    logic                                w_all_valid;
    logic [ICACHE_SET_ASSOC-1:0]         w_victim;
    logic                                w_found;
    logic [ICACHE_INDEX_WIDTH-1:0]       w_wr_index;
    logic [ICACHE_SET_ASSOC-1:0]         w_wr_way;
    logic [ICACHE_TAG_WIDTH-1:0]         w_wr_tag;
    logic                                w_wr_valid;
    logic                                w_unused_offset;

    assign w_miss_acc      = miss_valid_i && miss_ready_o;
    assign w_beat_fire     = (r_state == S_BEAT) && mem_rsp_valid_i;
    assign w_last_beat     = (r_beat_cnt == c_LAST_BEAT);
    assign w_last_set      = (r_flush_idx == c_LAST_SET);
    assign w_all_valid     = &miss_way_valid_i;
    assign w_unused_offset = ^miss_paddr_i[ICACHE_OFFSET_WIDTH-1:0];

    // Victim: lowest-numbered invalid way, else the round-robin pointer.
    always_comb begin
        w_victim = '0;
        w_found  = 1'b0;
        for (int i = 0; i < ICACHE_SET_ASSOC; i++) begin
            if (!w_found && !miss_way_valid_i[i]) begin
                w_victim[i] = 1'b1;
                w_found     = 1'b1;
            end
        end
        if (!w_found) begin
            w_victim = ICACHE_SET_ASSOC'(1) << r_rr_ptr;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a flush in IDLE takes priority over a miss.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (flush_i || r_flush_pend) begin
                    w_state_next = S_FLUSH;
                end else if (w_miss_acc) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready_i) begin
                    w_state_next = S_BEAT;
                end
            end
            S_BEAT: begin
                if (w_beat_fire && w_last_beat) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_state_next = r_flush_pend ? S_FLUSH : S_IDLE;
            end
            S_FLUSH: begin
                if (w_last_set) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Control outputs decoded from the current state.
    always_comb begin
        miss_ready_o    = (r_state == S_IDLE) && !flush_i && !r_flush_pend;
        mem_req_valid_o = (r_state == S_REQ);
        mem_rsp_ready_o = (r_state == S_BEAT);
        refill_we_o     = (r_state == S_WRITE) || (r_state == S_FLUSH);
        refill_done_o   = (r_state == S_WRITE);
        refill_err_o    = (r_state == S_WRITE) && r_err;
        flush_busy_o    = r_flush_pend || (r_state == S_FLUSH);
    end

    // Live array-write fields: flush writes clear every way of a set.
    always_comb begin
        if (r_state == S_FLUSH) begin
            w_wr_index = r_flush_idx;
            w_wr_way   = '1;
            w_wr_tag   = '0;
            w_wr_valid = 1'b0;
        end else begin
            w_wr_index = r_index;
            w_wr_way   = r_way;
            w_wr_tag   = r_tag;
            w_wr_valid = !r_err;
        end
    end

    assign mem_req_addr_o = {r_tag, r_index, {ICACHE_OFFSET_WIDTH{1'b0}}};
    assign refill_index_o = refill_we_o ? w_wr_index : r_hold_index;
    assign refill_way_o   = refill_we_o ? w_wr_way   : r_hold_way;
    assign refill_tag_o   = refill_we_o ? w_wr_tag   : r_hold_tag;
    assign refill_valid_o = refill_we_o ? w_wr_valid : r_hold_valid;
    assign refill_line_o  = (r_state == S_WRITE) ? r_line : r_hold_line;

    // Miss capture, victim pointer, beat assembly and error tracking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_index    <= '0;
            r_tag      <= '0;
            r_way      <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
            r_line     <= '0;
        end else begin
            if (w_miss_acc) begin
                r_index <= miss_paddr_i[ICACHE_OFFSET_WIDTH +: ICACHE_INDEX_WIDTH];
                r_tag   <= miss_paddr_i[PLEN-1 : ICACHE_OFFSET_WIDTH + ICACHE_INDEX_WIDTH];
                r_way   <= w_victim;
                // the pointer only moves when it actually chose the victim
                if (w_all_valid) begin
                    r_rr_ptr <= (r_rr_ptr == c_LAST_WAY) ? '0 : r_rr_ptr + 1'b1;
                end
            end
            if (w_beat_fire) begin
                r_line[r_beat_cnt] <= mem_rsp_data_i;
                r_beat_cnt         <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
                if (mem_rsp_err_i) begin
                    r_err <= 1'b1;
                end
            end
            if (r_state == S_WRITE) begin
                r_err <= 1'b0;
            end
        end
    end

    // Flush bookkeeping: remember flushes that arrive mid-refill, walk sets.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_flush_pend <= 1'b0;
            r_flush_idx  <= '0;
        end else begin
            if (flush_i && ((r_state == S_REQ) || (r_state == S_BEAT) || (r_state == S_WRITE))) begin
                r_flush_pend <= 1'b1;
            end else if ((r_state == S_FLUSH) && w_last_set) begin
                r_flush_pend <= 1'b0;
            end
            if (r_state == S_FLUSH) begin
                r_flush_idx <= w_last_set ? '0 : r_flush_idx + 1'b1;
            end
        end
    end

    // Capture the array-port fields so they stay put between writes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hold_index <= '0;
            r_hold_way   <= '0;
            r_hold_tag   <= '0;
            r_hold_valid <= 1'b0;
            r_hold_line  <= '0;
        end else begin
            if (refill_we_o) begin
                r_hold_index <= w_wr_index;
                r_hold_way   <= w_wr_way;
                r_hold_tag   <= w_wr_tag;
                r_hold_valid <= w_wr_valid;
            end
            if (r_state == S_WRITE) begin
                r_hold_line <= r_line;
            end
        end
    end

`ifdef ICACHE_REFILL_PERF_EN
    logic [31:0] r_perf_miss_cnt;
    logic [31:0] r_perf_busy_cnt;

    // Free-running wrap-around counters of accepted misses and refill cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_miss_cnt <= '0;
            r_perf_busy_cnt <= '0;
        end else begin
            if (w_miss_acc) begin
                r_perf_miss_cnt <= r_perf_miss_cnt + 32'd1;
            end
            if ((r_state == S_REQ) || (r_state == S_BEAT) || (r_state == S_WRITE)) begin
                r_perf_busy_cnt <= r_perf_busy_cnt + 32'd1;
            end
        end
    end

    assign perf_miss_cnt_o = r_perf_miss_cnt;
    assign perf_busy_cnt_o = r_perf_busy_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Miss/refill sequencer for the 4-bank, set-associative ICache. Accepts one line-miss request from the fetch stage, picks a victim way, and reads the line from memory in bus-width beats. It assembles the beats into a full line and issues a single write of data, tag and valid bit into the ICache arrays. It also walks every set to invalidate the cache on a flush (fence.i).

Parameters:
PLEN, 32, physical address width
ICACHE_LINE_WIDTH, 512, line size in bits
ICACHE_SET_ASSOC, 4, number of ways
ICACHE_NUM_SETS, 64, number of sets
ICACHE_INDEX_WIDTH, 6, $clog2(ICACHE_NUM_SETS)
ICACHE_OFFSET_WIDTH, 6, $clog2(ICACHE_LINE_WIDTH/8)
ICACHE_TAG_WIDTH, 20, PLEN-INDEX-OFFSET
BUS_WIDTH, 64, memory response beat width; BEATS=ICACHE_LINE_WIDTH/BUS_WIDTH (default 8); elaboration error unless divisible and BEATS>=2

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
miss_valid_i  in  1  miss request valid
miss_ready_o  out  1  miss accepted when valid&ready
miss_paddr_i  in  PLEN  missing physical address
miss_way_valid_i  in  ICACHE_SET_ASSOC  valid bits of the missed set, sampled at accept
mem_req_valid_o  out  1  line read request valid
mem_req_ready_i  in  1  memory accepts request
mem_req_addr_o  out  PLEN  line-aligned address
mem_rsp_valid_i  in  1  beat valid
mem_rsp_ready_o  out  1  beat accepted
mem_rsp_data_i  in  BUS_WIDTH  beat data
mem_rsp_err_i  in  1  beat error
flush_i  in  1  invalidate-all request (single-cycle pulse)
flush_busy_o  out  1  flush pending or in progress
refill_we_o  out  1  array write strobe
refill_index_o  out  ICACHE_INDEX_WIDTH  set index
refill_way_o  out  ICACHE_SET_ASSOC  one-hot way mask (all-ones during flush)
refill_tag_o  out  ICACHE_TAG_WIDTH  tag to write
refill_valid_o  out  1  valid bit to write
refill_line_o  out  ICACHE_LINE_WIDTH  assembled line
refill_done_o  out  1  one-cycle refill completion pulse
refill_err_o  out  1  accompanies done on bus error

Behaviour:
- Reset: state=IDLE; all outputs 0 except miss_ready_o=1. Beat counter, error flag, flush-pending flag and RR pointer are cleared; line buffer is zeroed. Reset mid-operation aborts immediately, with no array write.
- States: IDLE, REQ, BEAT, WRITE, FLUSH.
- IDLE: miss_ready_o = !flush_i && !flush_pend.
  - If flush_i or flush_pend, go to FLUSH.
  - Else, on miss handshake, latch index=paddr[OFFSET+:INDEX] and tag=paddr[PLEN-1:OFFSET+INDEX], then go to REQ.
  - Flush wins a same-cycle collision with a miss; the miss is not accepted.
- Victim selection, at accept: lowest-index invalid way. If all ways are valid, use the RR pointer (reset 0), which increments modulo ASSOC only on refills that used it.
- REQ: mem_req_valid_o=1 with addr={tag,index,OFFSET'0}, held stable until mem_req_ready_i, then go to BEAT.
- BEAT: mem_rsp_ready_o=1.
  - Beat k writes line bits [k*BUS_WIDTH +: BUS_WIDTH].
  - Any err is sticky-ORed into the error flag.
  - After beat BEATS-1, go to WRITE. No early exit on error.
- WRITE, one cycle:
  - refill_we_o=1, refill_done_o=1, refill_err_o=err flag, refill_valid_o=!err flag.
  - Next state: FLUSH if flush_pend, else IDLE; the error flag is cleared.
  - Miss-to-done latency = 1 (REQ) + request wait + beat cycles + 1.
- flush_i outside IDLE/FLUSH sets flush_pend and asserts flush_busy_o. flush_i during FLUSH is ignored.
- FLUSH: one set per cycle, index 0..NUM_SETS-1, refill_we_o=1, way=all ones, valid=0, tag=0.
  - After the last set, clear flush_pend and return to IDLE.
  - Takes NUM_SETS cycles; flush_busy_o is high throughout.
- refill_* outputs other than refill_we_o hold their last value when refill_we_o=0.

Optional Feature:
ICACHE_REFILL_PERF_EN:
- Defined: adds outputs perf_miss_cnt_o[31:0], incremented per accepted miss, and perf_busy_cnt_o[31:0], incremented each cycle in REQ/BEAT/WRITE. Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters do not exist.

Test Plan:
- Reset held 2 cycles -> all outputs 0, miss_ready_o=1, flush_busy_o=0.
- Miss paddr=0x8000_1234, way_valid=4'b0011, mem_req_ready_i held low 5 cycles, then 8 beats data=k -> request valid/addr 0x8000_1200 stable for 6 cycles. Write: index=0x08, tag=0x80001, way=4'b0100, valid=1, line beat k = k; done pulse 1 cycle after last beat.
- Three misses with way_valid=4'b1111 -> ways 0001, 0010, 0100; a fourth with way_valid=4'b1101 -> way 0010 and RR unchanged.
- mem_rsp_err_i on beat 3 only -> all 8 beats consumed; WRITE with valid=0, refill_err_o=1 and done=1 same cycle; the next refill has err=0.
- flush_i pulse during BEAT -> refill completes normally, then 64 consecutive writes index 0..63, way=4'b1111, valid=0. miss_ready_o=0 until IDLE; flush_busy_o high from pulse to end.
- flush_i and miss_valid_i same cycle in IDLE -> miss not accepted, flush runs, and the miss is accepted in the first IDLE cycle afterwards.
